// File: rtl/matmul_sequencer_if.sv
// Host and array-side signal bundle for the matmul sequencer.
// The sequencer connects through the slave modport; the host/array
// environment connects through the master modport.
interface matmul_sequencer_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int N      = BUS_WIDTH / DATA_WIDTH;
    localparam int NN     = N * N;
    localparam int ADDR_W = $clog2(NN);

    logic                    start_i;
    logic                    mode_i;
    logic                    wr_en_i;
    logic                    wr_sel_i;
    logic [ADDR_W-1:0]       wr_addr_i;
    logic [DATA_WIDTH-1:0]   wr_data_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [BUS_WIDTH-1:0]    a_bus_o;
    logic [BUS_WIDTH-1:0]    b_bus_o;
    logic [BUS_WIDTH*NN-1:0] c_bus_o;
    logic                    array_start_o;
    logic                    array_mode_o;
    logic                    array_done_i;
    logic [BUS_WIDTH*NN-1:0] array_m_i;
    logic [NN-1:0]           array_flags_i;
    logic [BUS_WIDTH*NN-1:0] res_o;
    logic [NN-1:0]           flags_o;

    modport slave (
        input  start_i, mode_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i,
               array_done_i, array_m_i, array_flags_i,
        output busy_o, done_o, err_o, a_bus_o, b_bus_o, c_bus_o,
               array_start_o, array_mode_o, res_o, flags_o
    );

    modport master (
        output start_i, mode_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i,
               array_done_i, array_m_i, array_flags_i,
        input  busy_o, done_o, err_o, a_bus_o, b_bus_o, c_bus_o,
               array_start_o, array_mode_o, res_o, flags_o
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequencer for an N x N systolic matmul array: buffers host operands,
// drives the skewed A/B wavefront, pulses the array start, waits for the
// array with a timeout and latches the result and carry flags.
module matmul_sequencer #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 2 * (BUS_WIDTH / DATA_WIDTH)
) (
    input logic               clk_i,
    input logic               rst_i,
    matmul_sequencer_if.slave bus
);
    localparam int N      = BUS_WIDTH / DATA_WIDTH;
    localparam int NN     = N * N;
    localparam int DW     = DATA_WIDTH;
    localparam int T_LAST = 3 * N - 3;
    localparam int T_W    = $clog2(3 * N - 2);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [T_W-1:0]          t_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    mode_q;
    logic                    err_q;
    logic                    done_q;
    logic [BUS_WIDTH*NN-1:0] res_q;
    logic [NN-1:0]           flags_q;
    logic [DW*NN-1:0]        a_buf;
    logic [DW*NN-1:0]        b_buf;
    logic [BUS_WIDTH-1:0]    a_bus;
    logic [BUS_WIDTH-1:0]    b_bus;
    logic                    accept_start;
    logic                    wait_last;
    logic                    timeout_hit;

    assign accept_start = (state == ST_IDLE) && bus.start_i;
    assign wait_last    = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign timeout_hit  = (state == ST_WAIT) && !bus.array_done_i && wait_last;

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the IDLE -> FEED -> WAIT -> CAPTURE cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_next = ST_FEED;
                end
            end
            ST_FEED: begin
                if (t_cnt == T_W'(T_LAST)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.array_done_i) begin
                    state_next = ST_CAPTURE;
                end else if (wait_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Wavefront step counter in FEED and elapsed-cycle counter in WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t_cnt    <= '0;
            wait_cnt <= '0;
        end else begin
            t_cnt    <= (state == ST_FEED) ? t_cnt + 1'b1 : '0;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Operand buffers accept host writes only while idle, so a run sees frozen data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if ((state == ST_IDLE) && bus.wr_en_i) begin
            if (bus.wr_sel_i) begin
                b_buf[int'(bus.wr_addr_i)*DW +: DW] <= bus.wr_data_i;
            end else begin
                a_buf[int'(bus.wr_addr_i)*DW +: DW] <= bus.wr_data_i;
            end
        end
    end

    // Run status: mode latch, sticky timeout error, completion pulse and result capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (accept_start) begin
                mode_q <= bus.mode_i;
            end
            if (accept_start) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
            done_q <= (state == ST_WAIT) && (bus.array_done_i || wait_last);
            if (state == ST_CAPTURE) begin
                res_q   <= bus.array_m_i;
                flags_q <= bus.array_flags_i;
            end
        end
    end

    // Skewed edge buses: row r carries A[r][t-r], column c carries B[t-c][c].
    always_comb begin
        a_bus = '0;
        b_bus = '0;
        if (state == ST_FEED) begin
            for (int r = 0; r < N; r++) begin
                if ((int'(t_cnt) >= r) && (int'(t_cnt) - r < N)) begin
                    a_bus[r*DW +: DW] = a_buf[(r*N + int'(t_cnt) - r)*DW +: DW];
                    b_bus[r*DW +: DW] = b_buf[((int'(t_cnt) - r)*N + r)*DW +: DW];
                end
            end
        end
    end

    assign bus.a_bus_o       = a_bus;
    assign bus.b_bus_o       = b_bus;
    assign bus.c_bus_o       = (mode_q && ((state == ST_FEED) || (state == ST_WAIT))) ? res_q : '0;
    assign bus.array_start_o = (state == ST_FEED) && (t_cnt == '0);
    assign bus.array_mode_o  = mode_q;
    assign bus.busy_o        = (state != ST_IDLE);
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;
    assign bus.res_o         = res_q;
    assign bus.flags_o       = flags_q;
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that sequences one MAX_DIM x MAX_DIM systolic matmul array (PE grid, operands enter on A/B edge buses, C preload, per-PE carry flags, array-level done).
- Holds host-loaded A and B operand buffers and drives the skewed operand wavefront onto the array edge buses.
- Pulses the array start bit, waits for array done with a timeout, and latches result and flags into host-visible registers.
- Supports accumulate mode, where the previous result is fed back as C, so results can be chained as M = A*B + M_prev.

Parameters:
- BUS_WIDTH, 16, edge bus width and width of each result element.
- DATA_WIDTH, 8, operand element width (signed).
- MAX_DIM, localparam BUS_WIDTH/DATA_WIDTH, matrix dimension N; must be >= 2.
- TIMEOUT, 2*MAX_DIM, maximum WAIT cycles for array_done_i.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  host request to run one multiplication.
- mode_i  in  1  0: C = 0; 1: accumulate, C = res_o.
- wr_en_i  in  1  operand buffer write strobe.
- wr_sel_i  in  1  0 selects the A buffer, 1 selects the B buffer.
- wr_addr_i  in  $clog2(N*N)  element index row*N+col.
- wr_data_i  in  DATA_WIDTH  operand element.
- busy_o  out  1  high in FEED, WAIT and CAPTURE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky timeout error.
- a_bus_o  out  BUS_WIDTH  A edge bus; lane r is bits [(r+1)*DW-1:r*DW].
- b_bus_o  out  BUS_WIDTH  B edge bus; lane c, same packing.
- c_bus_o  out  BUS_WIDTH*N*N  C preload.
- array_start_o  out  1  start bit to PE(0,0).
- array_mode_o  out  1  mode bit to the array.
- array_done_i  in  1  array-level done.
- array_m_i  in  BUS_WIDTH*N*N  array result.
- array_flags_i  in  N*N  array carry flags.
- res_o  out  BUS_WIDTH*N*N  latched result.
- flags_o  out  N*N  latched flags.

Behaviour:
- Reset: state IDLE, both operand buffers cleared. All outputs are 0, including res_o, flags_o and err_o.
- Reset asserted mid-operation aborts immediately with no done_o.
- States: IDLE -> FEED -> WAIT -> CAPTURE -> IDLE.
- IDLE:
  - wr_en_i writes wr_data_i into buffer[wr_sel_i][wr_addr_i].
  - start_i=1 moves to FEED next edge. The feed counter t is cleared and mode_i is latched into array_mode_o.
  - err_o clears on an accepted start.
  - A write in the same cycle as start_i is committed and is visible to the feed.
- FEED, t = 0 .. 3N-3 (counter width $clog2(3N-2)):
  - a_bus lane r = A[r][t-r] if 0 <= t-r < N, else 0.
  - b_bus lane c = B[t-c][c] if 0 <= t-c < N, else 0.
  - array_start_o = 1 only at t=0.
  - c_bus_o = res_o if the latched mode is 1, else 0; held constant through FEED and WAIT.
  - At t = 3N-3, move to WAIT.
- WAIT:
  - Both buses are 0.
  - array_done_i=1 -> CAPTURE.
  - After TIMEOUT cycles without array_done_i: set err_o, pulse done_o, return to IDLE. res_o and flags_o are unchanged.
- CAPTURE (1 cycle): res_o <= array_m_i, flags_o <= array_flags_i. done_o pulses in this cycle, then IDLE.
- busy: start_i and wr_en_i are ignored while busy_o=1. Buffers are frozen.
- array_done_i outside WAIT is ignored.
- Latency:
  - start accepted at edge k -> FEED during cycles k+1 .. k+3N-2.
  - Best case done_o is 2 cycles after the last FEED cycle (array_done_i in the first WAIT cycle).
- Arithmetic: the block does no arithmetic. Operands pass through unmodified, two's complement. Overflow is reported only through the array flags.

Test Plan:
- N=2, load A=[[1,2],[3,4]], B=[[5,6],[7,8]], mode 0, start -> bus sequence per cycle:
  - t0: a=(1,0), b=(5,0)
  - t1: a=(2,3), b=(7,6)
  - t2: a=(0,4), b=(0,8)
  - t3: all 0
  - array_start_o high only at t0; c_bus_o=0.
- Same operands with a model array that returns done -> res_o=[[19,22],[43,50]], done_o a single pulse, busy_o low afterwards.
- Repeat with mode_i=1 -> c_bus_o=[[19,22],[43,50]] during FEED; model result [[38,44],[86,100]] latched.
- array_done_i held low -> err_o=1 and done_o pulses exactly TIMEOUT=4 cycles after WAIT entry. res_o is unchanged; the next start clears err_o.
- start_i and wr_en_i pulsed while busy -> no restart; buffer contents verified unchanged on the following run.
- rst_i asserted during FEED at t=1 -> all outputs 0 asynchronously and buffers cleared. A subsequent start feeds all-zero operands.
